alu_operand_entry: RTL

Sequential keypad front-end for the 8-bit ALU: collects decimal digit keystrokes and converts them from BCD entry back to binary (the inverse of the result binary-to-BCD path). It assembles operand A, operand B and the 3-bit operation selector, then presents them to the ALU with a valid/ready handshake. It also exposes the in-progress entry value and field for the display path.

---
 rtl/alu_entry_pkg.sv | 19 +
 rtl/bcd_accumulate.sv | 23 ++
 rtl/alu_operand_entry.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_entry_pkg.sv
// Shared definitions for the ALU keypad operand-entry front-end:
// key codes, entry states and default sizing.
package alu_entry_pkg;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_MAX_DIGITS = 3;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  // Encoding is driven straight onto entry_field for the display path.
  typedef enum logic [1:0] {
    ENT_A  = 2'd0,
    ENT_B  = 2'd1,
    ENT_OP = 2'd2,
    READY  = 2'd3
  } entry_state_t;

endpackage

// File: rtl/bcd_accumulate.sv
// Decimal digit accumulation step: nxt = acc*10 + digit, with an overflow
// flag when the result no longer fits in DATA_W bits.
module bcd_accumulate #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] nxt,
  output logic              ovf
);

  localparam int unsigned SUM_W = DATA_W + 4;

  logic [SUM_W-1:0] sum;

  // 10*(2^DATA_W-1)+9 always fits in DATA_W+4 bits.
  always_comb begin
    sum = SUM_W'(acc) * SUM_W'(10) + SUM_W'(digit);
    nxt = sum[DATA_W-1:0];
    ovf = |sum[SUM_W-1:DATA_W];
  end

endmodule

// File: rtl/alu_operand_entry.sv
// Keypad front-end for the ALU: assembles operand A, operand B and the
// operation selector from decimal keystrokes and offers them via valid/ready.
module alu_operand_entry
  import alu_entry_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MAX_DIGITS = DEF_MAX_DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        op_sel,
  output logic              op_valid,
  output logic [DATA_W-1:0] entry_val,
  output logic [1:0]        entry_field,
  output logic              entry_err
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  entry_state_t      state;
  entry_state_t      state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] op_a_nxt;
  logic [DATA_W-1:0] op_b_nxt;
  logic [2:0]        op_sel_nxt;
  logic              op_valid_nxt;
  logic              err_nxt;
  logic [DATA_W-1:0] bcd_nxt;
  logic              bcd_ovf;
  logic              key_digit;
  logic              key_enter;
  logic              key_clear;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_enter = key_valid && (key_code == KEY_ENTER);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);

  assign entry_field = 2'(state);

  bcd_accumulate #(
    .DATA_W (DATA_W)
  ) u_bcd_accumulate (
    .acc   (entry_val),
    .digit (key_code),
    .nxt   (bcd_nxt),
    .ovf   (bcd_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENT_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; CLEAR overrides everything, including a READY transfer
  always_comb begin
    state_nxt = state;
    if (key_clear) begin
      state_nxt = ENT_A;
    end else begin
      case (state)
        ENT_A:   if (key_enter) state_nxt = ENT_B;
        ENT_B:   if (key_enter) state_nxt = ENT_OP;
        ENT_OP:  if (key_enter && (cnt != '0)) state_nxt = READY;
        READY:   if (op_ready) state_nxt = ENT_A;
        default: state_nxt = ENT_A;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    acc_nxt      = entry_val;
    cnt_nxt      = cnt;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    op_sel_nxt   = op_sel;
    op_valid_nxt = op_valid;
    err_nxt      = 1'b0;
    if (key_clear) begin
      acc_nxt      = '0;
      cnt_nxt      = '0;
      op_valid_nxt = 1'b0;
    end else begin
      case (state)
        ENT_A, ENT_B: begin
          if (key_digit) begin
            if ((cnt == CNT_W'(MAX_DIGITS)) || bcd_ovf) begin
              err_nxt = 1'b1;
            end else begin
              acc_nxt = bcd_nxt;
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else if (key_enter) begin
            if (state == ENT_A) begin
              op_a_nxt = entry_val;
            end else begin
              op_b_nxt = entry_val;
            end
            acc_nxt = '0;
            cnt_nxt = '0;
          end
        end
        ENT_OP: begin
          if (key_digit) begin
            // Only 0-7 name an operation; the last accepted digit wins.
            if (key_code[3]) begin
              err_nxt = 1'b1;
            end else begin
              acc_nxt = DATA_W'(key_code[2:0]);
              cnt_nxt = CNT_W'(1);
            end
          end else if (key_enter) begin
            if (cnt == '0) begin
              err_nxt = 1'b1;
            end else begin
              op_sel_nxt   = entry_val[2:0];
              acc_nxt      = '0;
              cnt_nxt      = '0;
              op_valid_nxt = 1'b1;
            end
          end
        end
        READY: begin
          if (key_digit || key_enter) begin
            err_nxt = 1'b1;
          end
          if (op_ready) begin
            op_valid_nxt = 1'b0;
          end
        end
        default: begin
          acc_nxt = '0;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      entry_val <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      op_valid  <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      entry_val <= acc_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      op_sel    <= op_sel_nxt;
      op_valid  <= op_valid_nxt;
      entry_err <= err_nxt;
    end
  end

endmodule
